// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  typedef enum logic [1:0] {REQ_FETCH, REQ_RD, REQ_WR} req_id_e;

  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker between the FETCH class (bit 0) and the DATA class (bit 1).
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_gnt
);

  // 1 = DATA was granted last; resetting to DATA lets FETCH win first.
  logic r_last;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_last <= 1'b1;
    end else if (i_update) begin
      r_last <= o_gnt[1];
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch, load and store requesters,
// one transaction at a time, routing each response back to its issuer.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
)
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              fetch_req_valid,
  output logic              fetch_req_ready,
  input  logic [ADDR_W-1:0] fetch_req_addr,
  output logic              fetch_rsp_valid,
  output logic [DATA_W-1:0] fetch_rsp_data,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_rsp_valid,
  output logic [DATA_W-1:0] rd_rsp_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              wr_rsp_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e           r_state;
  req_id_e              r_id;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic                 r_mem_en;
  logic                 r_mem_we;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic                 r_fetch_rsp_valid;
  logic                 r_rd_rsp_valid;
  logic                 r_wr_rsp_valid;
  logic [DATA_W-1:0]    r_fetch_rsp_data;
  logic [DATA_W-1:0]    r_rd_rsp_data;

  logic                 w_idle;
  logic [1:0]           w_gnt;
  logic                 w_accept;
  req_id_e              w_sel_id;
  logic [ADDR_W-1:0]    w_sel_addr;

  // Ready is withheld while RESET is high so no handshake completes that reset discards.
  assign w_idle = (r_state == IDLE) && !RESET;

  mem_arb_rr u_rr (
    .clk      (CLK),
    .srst     (RESET),
    .i_req    ({rd_req_valid | wr_req_valid, fetch_req_valid}),
    .i_update (w_accept),
    .o_gnt    (w_gnt)
  );

  assign fetch_req_ready = w_idle && w_gnt[0];
  assign wr_req_ready    = w_idle && w_gnt[1] && wr_req_valid;
  assign rd_req_ready    = w_idle && w_gnt[1] && !wr_req_valid;
  assign w_accept        = fetch_req_ready || rd_req_ready || wr_req_ready;

  always_comb begin
    w_sel_id   = REQ_FETCH;
    w_sel_addr = fetch_req_addr;
    if (wr_req_ready) begin
      w_sel_id   = REQ_WR;
      w_sel_addr = wr_req_addr;
    end else if (rd_req_ready) begin
      w_sel_id   = REQ_RD;
      w_sel_addr = rd_req_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state           <= IDLE;
      r_id              <= REQ_FETCH;
      r_cnt             <= '0;
      r_mem_en          <= 1'b0;
      r_mem_we          <= 1'b0;
      r_mem_addr        <= '0;
      r_mem_wdata       <= '0;
      r_fetch_rsp_valid <= 1'b0;
      r_rd_rsp_valid    <= 1'b0;
      r_wr_rsp_valid    <= 1'b0;
      r_fetch_rsp_data  <= '0;
      r_rd_rsp_data     <= '0;
    end else begin
      r_mem_en          <= 1'b0;
      r_mem_we          <= 1'b0;
      r_fetch_rsp_valid <= 1'b0;
      r_rd_rsp_valid    <= 1'b0;
      r_wr_rsp_valid    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state     <= ISSUE;
            r_id        <= w_sel_id;
            r_mem_en    <= 1'b1;
            r_mem_we    <= wr_req_ready;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= wr_req_data;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
          r_cnt   <= LAT_CNT_W'(MEM_LAT);
        end
        WAIT: begin
          // The last WAIT cycle is the one in which mem_rdata is valid.
          if (r_cnt == LAT_CNT_W'(1)) begin
            r_state <= RESP;
            if (r_id == REQ_FETCH) begin
              r_fetch_rsp_valid <= 1'b1;
              r_fetch_rsp_data  <= mem_rdata;
            end else if (r_id == REQ_RD) begin
              r_rd_rsp_valid <= 1'b1;
              r_rd_rsp_data  <= mem_rdata;
            end else begin
              r_wr_rsp_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - LAT_CNT_W'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_en          = r_mem_en;
  assign mem_we          = r_mem_we;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign fetch_rsp_valid = r_fetch_rsp_valid;
  assign fetch_rsp_data  = r_fetch_rsp_data;
  assign rd_rsp_valid    = r_rd_rsp_valid;
  assign rd_rsp_data     = r_rd_rsp_data;
  assign wr_rsp_valid    = r_wr_rsp_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter at MEM_LAT=1 and MEM_LAT=4, checked against a
// timestamp-based transaction model (accept cycle -> issue and response cycles).
module tb_mem_port_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  localparam int NCYC    = 2500;
  localparam int ID_NONE = 0;
  localparam int ID_F    = 1;
  localparam int ID_R    = 2;
  localparam int ID_W    = 3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_lat
    localparam int LAT = (gi == 0) ? 1 : 4;

    logic        RESET;
    logic        fetch_req_valid, fetch_req_ready, fetch_rsp_valid;
    logic [31:0] fetch_req_addr, fetch_rsp_data;
    logic        rd_req_valid, rd_req_ready, rd_rsp_valid;
    logic [31:0] rd_req_addr, rd_rsp_data;
    logic        wr_req_valid, wr_req_ready, wr_rsp_valid;
    logic [31:0] wr_req_addr, wr_req_data;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .fetch_req_valid (fetch_req_valid),
      .fetch_req_ready (fetch_req_ready),
      .fetch_req_addr  (fetch_req_addr),
      .fetch_rsp_valid (fetch_rsp_valid),
      .fetch_rsp_data  (fetch_rsp_data),
      .rd_req_valid    (rd_req_valid),
      .rd_req_ready    (rd_req_ready),
      .rd_req_addr     (rd_req_addr),
      .rd_rsp_valid    (rd_rsp_valid),
      .rd_rsp_data     (rd_rsp_data),
      .wr_req_valid    (wr_req_valid),
      .wr_req_ready    (wr_req_ready),
      .wr_req_addr     (wr_req_addr),
      .wr_req_data     (wr_req_data),
      .wr_rsp_valid    (wr_rsp_valid),
      .mem_en          (mem_en),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata)
    );

    initial begin : run
      int          next_free, p_acc, p_id, gid, acc_prev;
      bit          pend, last_data, rst_now, rst_prev, data_req, rsp, issue;
      logic [31:0] p_addr, p_wdata, p_rdata, exp_fdata, exp_rdata;
      string       pfx;

      pfx             = $sformatf("L%0d", LAT);
      RESET           = 1'b1;
      fetch_req_valid = 1'b0;
      rd_req_valid    = 1'b0;
      wr_req_valid    = 1'b0;
      fetch_req_addr  = '0;
      rd_req_addr     = '0;
      wr_req_addr     = '0;
      wr_req_data     = '0;
      mem_rdata       = '0;
      repeat (2) @(negedge CLK);
      check({pfx, " rst mem_en"}, mem_en, 0);
      check({pfx, " rst mem_we"}, mem_we, 0);
      check({pfx, " rst mem_addr"}, mem_addr, 0);
      check({pfx, " rst mem_wdata"}, mem_wdata, 0);
      check({pfx, " rst rsp_valids"}, {fetch_rsp_valid, rd_rsp_valid, wr_rsp_valid}, 0);
      check({pfx, " rst fetch_rsp_data"}, fetch_rsp_data, 0);
      check({pfx, " rst rd_rsp_data"}, rd_rsp_data, 0);
      check({pfx, " rst readies"}, {fetch_req_ready, rd_req_ready, wr_req_ready}, 0);

      next_free = 0;
      last_data = 1'b1;
      pend      = 1'b0;
      p_acc     = 0;
      p_id      = ID_NONE;
      p_addr    = '0;
      p_wdata   = '0;
      p_rdata   = '0;
      exp_fdata = '0;
      exp_rdata = '0;
      acc_prev  = ID_NONE;
      rst_prev  = 1'b0;

      for (int c = 0; c < NCYC; c++) begin
        @(negedge CLK);
        if (acc_prev == ID_F) fetch_req_valid = 1'b0;
        if (acc_prev == ID_R) rd_req_valid = 1'b0;
        if (acc_prev == ID_W) wr_req_valid = 1'b0;
        rst_now = (c > 30) && ($urandom_range(0, 149) == 0);
        RESET   = rst_now;

        // New requests appear at random; an unaccepted one is occasionally withdrawn.
        if (!fetch_req_valid) begin
          if ($urandom_range(0, 2) == 0) begin
            fetch_req_valid = 1'b1;
            fetch_req_addr  = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) fetch_req_valid = 1'b0;
        if (!rd_req_valid) begin
          if ($urandom_range(0, 2) == 0) begin
            rd_req_valid = 1'b1;
            rd_req_addr  = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) rd_req_valid = 1'b0;
        if (!wr_req_valid) begin
          if ($urandom_range(0, 3) == 0) begin
            wr_req_valid = 1'b1;
            wr_req_addr  = $urandom;
            wr_req_data  = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) wr_req_valid = 1'b0;

        // Read data is only meaningful in the cycle MEM_LAT after mem_en; noise otherwise.
        mem_rdata = (pend && c == p_acc + 1 + LAT) ? p_rdata : $urandom;
        #1;

        if (rst_prev) begin
          check($sformatf("%s post-rst mem_addr c%0d", pfx, c), mem_addr, 0);
          check($sformatf("%s post-rst mem_wdata c%0d", pfx, c), mem_wdata, 0);
        end

        gid      = ID_NONE;
        data_req = rd_req_valid || wr_req_valid;
        if (c >= next_free) begin
          if (fetch_req_valid && (!data_req || last_data)) gid = ID_F;
          else if (wr_req_valid) gid = ID_W;
          else if (rd_req_valid) gid = ID_R;
        end
        if (!rst_now) begin
          check($sformatf("%s fetch_req_ready c%0d", pfx, c), fetch_req_ready, gid == ID_F);
          check($sformatf("%s rd_req_ready c%0d", pfx, c), rd_req_ready, gid == ID_R);
          check($sformatf("%s wr_req_ready c%0d", pfx, c), wr_req_ready, gid == ID_W);
        end

        issue = pend && (c == p_acc + 1);
        check($sformatf("%s mem_en c%0d", pfx, c), mem_en, issue);
        if (issue) begin
          check($sformatf("%s mem_we c%0d", pfx, c), mem_we, p_id == ID_W);
          check($sformatf("%s mem_addr c%0d", pfx, c), mem_addr, p_addr);
          if (p_id == ID_W) check($sformatf("%s mem_wdata c%0d", pfx, c), mem_wdata, p_wdata);
        end

        rsp = pend && (c == p_acc + 2 + LAT);
        if (rsp && p_id == ID_F) exp_fdata = p_rdata;
        if (rsp && p_id == ID_R) exp_rdata = p_rdata;
        check($sformatf("%s fetch_rsp_valid c%0d", pfx, c), fetch_rsp_valid, rsp && p_id == ID_F);
        check($sformatf("%s rd_rsp_valid c%0d", pfx, c), rd_rsp_valid, rsp && p_id == ID_R);
        check($sformatf("%s wr_rsp_valid c%0d", pfx, c), wr_rsp_valid, rsp && p_id == ID_W);
        check($sformatf("%s fetch_rsp_data c%0d", pfx, c), fetch_rsp_data, exp_fdata);
        check($sformatf("%s rd_rsp_data c%0d", pfx, c), rd_rsp_data, exp_rdata);
        if (rsp) begin
          $display("%s txn id=%0d acc=%0d rsp=%0d addr=%08h data=%08h",
                   pfx, p_id, p_acc, c, p_addr, (p_id == ID_W) ? p_wdata : p_rdata);
          pend = 1'b0;
        end

        acc_prev = ID_NONE;
        if (rst_now) begin
          pend      = 1'b0;
          next_free = c + 1;
          last_data = 1'b1;
          exp_fdata = '0;
          exp_rdata = '0;
        end else if (gid != ID_NONE) begin
          pend      = 1'b1;
          p_id      = gid;
          p_acc     = c;
          p_addr    = (gid == ID_F) ? fetch_req_addr : (gid == ID_R) ? rd_req_addr : wr_req_addr;
          p_wdata   = wr_req_data;
          p_rdata   = $urandom;
          next_free = c + LAT + 3;
          last_data = (gid != ID_F);
          acc_prev  = gid;
        end
        rst_prev = rst_now;
      end
      n_done++;
    end
  end

  initial begin : finish_ctl
    int waited;
    waited = 0;
    while (n_done < 2 && waited < 40000) begin
      @(posedge CLK);
      waited++;
    end
    check("run_complete", n_done, 2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
